// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared widths and types for the SIMPLE pipeline stages
package simple_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 16;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/simple_regfile.sv
// rtl/simple_regfile.sv - 2**ADDR_W entry register file, one write port, two bypassed read ports (SIMPLE_RF_ZERO_REG_EN hardwires r0)
module simple_regfile
  import simple_pkg::*;
#(
  parameter int DATA_W = simple_pkg::DATA_W,
  parameter int ADDR_W = simple_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

`ifdef SIMPLE_RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] rf_q [DEPTH];
  logic [DATA_W-1:0] rf_d [DEPTH];
  logic              wr_en;

  // Writes to a hardwired r0 never reach the array
  always_comb begin
    wr_en = we && !(ZERO_REG && (waddr == '0));
  end

  // Next array state: copy, then overlay the single write
  always_comb begin
    rf_d = rf_q;
    if (wr_en) begin
      rf_d[waddr] = wdata;
    end
  end

  // Array storage, cleared by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Port A: array read, write-through bypass, then r0 override
  always_comb begin
    rdata_a = rf_q[raddr_a];
    if (we && (raddr_a == waddr)) begin
      rdata_a = wdata;
    end
    if (ZERO_REG && (raddr_a == '0)) begin
      rdata_a = '0;
    end
  end

  // Port B: same structure as port A
  always_comb begin
    rdata_b = rf_q[raddr_b];
    if (we && (raddr_b == waddr)) begin
      rdata_b = wdata;
    end
    if (ZERO_REG && (raddr_b == '0)) begin
      rdata_b = '0;
    end
  end

endmodule

// File: rtl/simple_writeback_rf.sv
// rtl/simple_writeback_rf.sv - writeback stage: commit mux, register file, writeback record, retire counter (SIMPLE_RF_ZERO_REG_EN)
module simple_writeback_rf
  import simple_pkg::*;
#(
  parameter int DATA_W = simple_pkg::DATA_W,
  parameter int ADDR_W = simple_pkg::ADDR_W,
  parameter int CNT_W  = simple_pkg::CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_reg,
  input  logic [ADDR_W-1:0] reg_address,
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] alu_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [CNT_W-1:0]  retire_count
);

  logic [DATA_W-1:0] commit_data;

  logic              wb_valid_d, wb_valid_q;
  logic [ADDR_W-1:0] wb_addr_d,  wb_addr_q;
  logic [DATA_W-1:0] wb_data_d,  wb_data_q;
  logic [CNT_W-1:0]  retire_d,   retire_q;

  // Select the value being committed this cycle
  always_comb begin
    commit_data = mem_to_reg ? mem_data : alu_data;
  end

  simple_regfile #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_regfile (
    .clock   (clock),
    .reset   (reset),
    .we      (write_reg),
    .waddr   (reg_address),
    .wdata   (commit_data),
    .raddr_a (rd_addr_a),
    .raddr_b (rd_addr_b),
    .rdata_a (rd_data_a),
    .rdata_b (rd_data_b)
  );

  // Writeback record and retire count; record holds when nothing commits, count wraps freely
  always_comb begin
    wb_valid_d = write_reg;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    retire_d   = retire_q;
    if (write_reg) begin
      wb_addr_d = reg_address;
      wb_data_d = commit_data;
      retire_d  = retire_q + 1'b1;
    end
  end

  // Writeback record and counter registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      retire_q   <= '0;
    end else begin
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      retire_q   <= retire_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_simple_writeback_rf.sv
// tb/tb_simple_writeback_rf.sv - directed self-checking bench for simple_writeback_rf (SIMPLE_RF_ZERO_REG_EN aware)
module tb_simple_writeback_rf;

`ifdef SIMPLE_RF_ZERO_REG_EN
  localparam logic [15:0] R0_EXP = 16'h0000;
`else
  localparam logic [15:0] R0_EXP = 16'h5555;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        write_reg;
  logic [2:0]  reg_address;
  logic        mem_to_reg;
  logic [15:0] mem_data;
  logic [15:0] alu_data;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic        wb_valid;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] retire_count;

  int checks = 0;
  int errors = 0;

  simple_writeback_rf dut (
    .clock        (clock),
    .reset        (reset),
    .write_reg    (write_reg),
    .reg_address  (reg_address),
    .mem_to_reg   (mem_to_reg),
    .mem_data     (mem_data),
    .alu_data     (alu_data),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .wb_valid     (wb_valid),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .retire_count (retire_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] addr, input logic m2r,
                       input logic [15:0] md, input logic [15:0] ad);
    write_reg   = we;
    reg_address = addr;
    mem_to_reg  = m2r;
    mem_data    = md;
    alu_data    = ad;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 16'h0000, 16'h0000);
    rd_addr_a = 3'd0;
    rd_addr_b = 3'd0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state: every address reads zero on both ports
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      #1;
      chk($sformatf("reset_rd_a%0d", i), {16'h0, rd_data_a}, 32'h0);
      chk($sformatf("reset_rd_b%0d", 7 - i), {16'h0, rd_data_b}, 32'h0);
    end
    chk("reset_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("reset_retire", {16'h0, retire_count}, 32'h0);

    // Bypass of mem_data into r3
    @(negedge clock);
    drive(1'b1, 3'd3, 1'b1, 16'hBEEF, 16'h1234);
    rd_addr_a = 3'd3;
    #1;
    chk("byp_r3_a", {16'h0, rd_data_a}, 32'hBEEF);
    @(posedge clock); #1;
    chk("c1_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("c1_wb_addr", {29'h0, wb_addr}, 32'h3);
    chk("c1_wb_data", {16'h0, wb_data}, 32'hBEEF);
    chk("c1_retire", {16'h0, retire_count}, 32'h1);
    write_reg = 1'b0;
    #1;
    chk("rf_r3_a", {16'h0, rd_data_a}, 32'hBEEF);

    // Back-to-back commits to r5 from alu_data, both ports watching
    @(negedge clock);
    drive(1'b1, 3'd5, 1'b0, 16'hFFFF, 16'h0001);
    rd_addr_a = 3'd5;
    rd_addr_b = 3'd5;
    #1;
    chk("r5_1_a", {16'h0, rd_data_a}, 32'h0001);
    chk("r5_1_b", {16'h0, rd_data_b}, 32'h0001);
    @(posedge clock); #1;
    chk("r5_1_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("r5_1_wb_data", {16'h0, wb_data}, 32'h0001);
    @(negedge clock);
    alu_data = 16'h0002;
    #1;
    chk("r5_2_a", {16'h0, rd_data_a}, 32'h0002);
    chk("r5_2_b", {16'h0, rd_data_b}, 32'h0002);
    @(posedge clock); #1;
    chk("r5_2_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("r5_2_wb_data", {16'h0, wb_data}, 32'h0002);
    @(negedge clock);
    drive(1'b0, 3'd5, 1'b0, 16'hFFFF, 16'h3333);
    #1;
    chk("r5_hold_a", {16'h0, rd_data_a}, 32'h0002);
    chk("r5_hold_b", {16'h0, rd_data_b}, 32'h0002);
    @(posedge clock); #1;
    chk("r5_wb_valid_drop", {31'h0, wb_valid}, 32'h0);
    chk("r5_wb_addr_hold", {29'h0, wb_addr}, 32'h5);
    chk("r5_wb_data_hold", {16'h0, wb_data}, 32'h0002);
    chk("r5_retire", {16'h0, retire_count}, 32'h3);

    // Counter wrap: 3 + 65532 = 0xFFFF, one more wraps to 0
    @(negedge clock);
    drive(1'b1, 3'd6, 1'b0, 16'h0000, 16'h0006);
    repeat (65532) @(posedge clock);
    #1;
    chk("retire_max", {16'h0, retire_count}, 32'hFFFF);
    @(posedge clock); #1;
    chk("retire_wrap", {16'h0, retire_count}, 32'h0);
    @(negedge clock);
    write_reg = 1'b0;
    rd_addr_b = 3'd6;
    #1;
    chk("rf_r6_b", {16'h0, rd_data_b}, 32'h0006);

    // Asynchronous reset between edges after populating r1
    @(negedge clock);
    drive(1'b1, 3'd1, 1'b1, 16'hAAAA, 16'h0BAD);
    @(posedge clock); #1;
    chk("r1_wb_data", {16'h0, wb_data}, 32'hAAAA);
    @(negedge clock);
    write_reg = 1'b0;
    rd_addr_a = 3'd1;
    #1;
    chk("r1_rd_a", {16'h0, rd_data_a}, 32'hAAAA);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_r1", {16'h0, rd_data_a}, 32'h0);
    chk("arst_wb_valid", {31'h0, wb_valid}, 32'h0);
    chk("arst_wb_addr", {29'h0, wb_addr}, 32'h0);
    chk("arst_wb_data", {16'h0, wb_data}, 32'h0);
    chk("arst_retire", {16'h0, retire_count}, 32'h0);
    #1;
    reset = 1'b0;
    drive(1'b1, 3'd2, 1'b0, 16'h0000, 16'h7777);
    rd_addr_b = 3'd2;
    @(posedge clock); #1;
    chk("post_rst_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("post_rst_wb_addr", {29'h0, wb_addr}, 32'h2);
    chk("post_rst_wb_data", {16'h0, wb_data}, 32'h7777);
    chk("post_rst_retire", {16'h0, retire_count}, 32'h1);
    @(negedge clock);
    write_reg = 1'b0;
    #1;
    chk("post_rst_r2_b", {16'h0, rd_data_b}, 32'h7777);

    // Commit to r0: hardwired zero only when the feature is built in
    @(negedge clock);
    drive(1'b1, 3'd0, 1'b1, 16'h5555, 16'h1111);
    rd_addr_a = 3'd0;
    #1;
    chk("r0_same_cycle", {16'h0, rd_data_a}, {16'h0, R0_EXP});
    @(posedge clock); #1;
    chk("r0_wb_valid", {31'h0, wb_valid}, 32'h1);
    chk("r0_wb_addr", {29'h0, wb_addr}, 32'h0);
    chk("r0_wb_data", {16'h0, wb_data}, 32'h5555);
    chk("r0_retire", {16'h0, retire_count}, 32'h2);
    @(negedge clock);
    write_reg = 1'b0;
    #1;
    chk("r0_next_cycle", {16'h0, rd_data_a}, {16'h0, R0_EXP});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simple_writeback_rf.md
Name: simple_writeback_rf

Overview:
- Writeback end of the SIMPLE pipeline; consumes the memory-stage outputs (register-write enable, destination address, load data) plus the ALU result.
- Commits the selected value into an 8 x 16-bit register file.
- Serves two operand read ports to decode with write-through bypass.
- Publishes a registered writeback record for forwarding, plus a retire counter.

Parameters:
- DATA_W, 16, register and data width
- ADDR_W, 3, register address width (2**ADDR_W registers)
- CNT_W, 16, retire counter width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- write_reg  in  1  commit request from the memory stage
- reg_address  in  ADDR_W  destination register
- mem_to_reg  in  1  1 = commit mem_data, 0 = commit alu_data
- mem_data  in  DATA_W  load data from the memory stage
- alu_data  in  DATA_W  ALU result carried alongside
- rd_addr_a  in  ADDR_W  operand A read address
- rd_addr_b  in  ADDR_W  operand B read address
- rd_data_a  out  DATA_W  operand A, combinational, with bypass
- rd_data_b  out  DATA_W  operand B, combinational, with bypass
- wb_valid  out  1  registered: a commit happened last cycle
- wb_addr  out  ADDR_W  registered destination of last commit
- wb_data  out  DATA_W  registered value of last commit
- retire_count  out  CNT_W  number of commits since reset

Behaviour:
- commit_data = mem_to_reg ? mem_data : alu_data, computed combinationally.
- Commit: on a rising clock edge with write_reg=1, rf[reg_address] <= commit_data. One edge of latency; no handshake and no stall; every asserted cycle commits.
- write_reg=0: the register file is unchanged; mem_to_reg, mem_data and alu_data are ignored.
- Read: rd_data_x = rf[rd_addr_x] in the same cycle.
- Bypass: if write_reg=1 and rd_addr_x == reg_address, rd_data_x = commit_data, giving write-before-read within the cycle. Both ports may bypass simultaneously. With identical addresses on both ports, both return the same value.
- Writeback record, updated every edge: wb_valid <= write_reg. When write_reg=1, wb_addr <= reg_address and wb_data <= commit_data; otherwise wb_addr and wb_data hold.
- retire_count increments by 1 on each commit edge. It wraps from 2**CNT_W-1 to 0 with no saturation and no flag.
- Back-to-back commits to the same register: the last edge wins; the bypass always reflects the current-cycle request.
- Reset (asynchronous, active-high): all rf entries, wb_valid, wb_addr, wb_data and retire_count go to 0 immediately, and commits are blocked while reset=1. rd_data_x then reads 0, except when the bypass hits, since the bypass is combinational.
- Reset deasserted mid-stream: the first rising edge with reset=0 commits normally.
- No X propagation: all storage is reset; the outputs are fully defined after reset.

Optional Feature:
- Macro: SIMPLE_RF_ZERO_REG_EN
- Defined: register 0 is hardwired to zero. Commits to address 0 are dropped from the array, and reads of address 0 return 0, bypass included. Such commits still set wb_valid, wb_addr=0, wb_data=commit_data and still increment retire_count.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package simple_pkg: DATA_W, ADDR_W, and the typedefs reg_addr_t (logic [ADDR_W-1:0]) and word_t (logic [DATA_W-1:0]).
- Shared with the other pipeline stages.
- One natural sub-module, simple_regfile: the 8-entry array with one write port, two read ports and the bypass.
- The top level holds the commit mux, the writeback record and the counter.

Test Plan:
- Reset, then read all 8 addresses on both ports -> every read returns 0x0000; wb_valid=0; retire_count=0.
- write_reg=1, reg_address=3, mem_to_reg=1, mem_data=0xBEEF, alu_data=0x1234, rd_addr_a=3 in the same cycle -> rd_data_a=0xBEEF before the edge (bypass). After the edge: rf[3]=0xBEEF, wb_valid=1, wb_addr=3, wb_data=0xBEEF, retire_count=1.
- Commits to r5 of alu_data 0x0001 then 0x0002 on consecutive cycles, rd_addr_a=rd_addr_b=5 -> both ports show 0x0001 then 0x0002, then hold 0x0002 with write_reg=0. wb_valid pulses 1,1,0 and wb_data holds 0x0002.
- Force retire_count to 0xFFFF via 65535 commits, then commit once more -> retire_count=0x0000.
- Assert reset asynchronously between edges after populating r1=0xAAAA -> rf[1], wb_* and retire_count read 0 before the next edge. The first commit after release works.
- With SIMPLE_RF_ZERO_REG_EN: commit 0x5555 to r0 -> rd_data_a at address 0 reads 0 in the same and the next cycle; wb_data=0x5555; retire_count increments. Without the macro: r0 reads 0x5555.
